// File: rtl/sirv_gnrl_rr_arb.sv
// rtl/sirv_gnrl_rr_arb.sv - N-way round-robin arbiter with registered output stage
// Requests are masked by a software-writable enable register; ptr advances only on an accept.
module sirv_gnrl_rr_arb #(
  parameter int N  = 4,
  parameter int DW = 32,
  parameter int IW = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req_valid,
  input  logic [N*DW-1:0] req_data,
  output logic [N-1:0]    req_ready,
  output logic            o_valid,
  output logic [DW-1:0]   o_data,
  output logic [IW-1:0]   o_id,
  input  logic            o_ready,
  input  logic            en_we,
  input  logic [N-1:0]    en_wdata,
  output logic [N-1:0]    en_mask
);

  logic [IW-1:0] ptr;
  logic [N-1:0]  eligible;
  logic [IW-1:0] winner;
  logic          found;
  logic [DW-1:0] win_data;
  logic [IW-1:0] ptr_next;
  logic          load_ok;
  logic          accept;
  int            idx;

  assign eligible = req_valid & en_mask;
  assign load_ok  = !o_valid || o_ready;
  // rst_n gates the accept so no grant leaks out while reset is held.
  assign accept   = rst_n && load_ok && found;

  // Circular search starting at ptr.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!found && eligible[idx]) begin
        found  = 1'b1;
        winner = IW'(idx);
      end
    end
  end

  always_comb begin
    win_data = '0;
    for (int i = 0; i < N; i++) begin
      if (winner == IW'(i)) win_data = req_data[i*DW +: DW];
    end
  end

  assign ptr_next = (winner == IW'(N-1)) ? '0 : winner + 1'b1;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[winner] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_id    <= '0;
      ptr     <= '0;
      en_mask <= '1;
    end else begin
      if (accept) begin
        o_valid <= 1'b1;
        o_data  <= win_data;
        o_id    <= winner;
        ptr     <= ptr_next;
      end else if (o_valid && o_ready) begin
        o_valid <= 1'b0;
      end
      if (en_we) en_mask <= en_wdata;
    end
  end

endmodule

// File: tb/tb_sirv_gnrl_rr_arb.sv
// tb/tb_sirv_gnrl_rr_arb.sv - directed self-checking bench for sirv_gnrl_rr_arb
module tb_sirv_gnrl_rr_arb;

  logic          clk;
  logic          rst_n;
  logic [3:0]    req_valid;
  logic [127:0]  req_data;
  logic [3:0]    req_ready;
  logic          o_valid;
  logic [31:0]   o_data;
  logic [1:0]    o_id;
  logic          o_ready;
  logic          en_we;
  logic [3:0]    en_wdata;
  logic [3:0]    en_mask;

  int n_cmp = 0;
  int n_err = 0;

  sirv_gnrl_rr_arb #(.N(4), .DW(32), .IW(2)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .o_valid(o_valid), .o_data(o_data), .o_id(o_id),
    .o_ready(o_ready), .en_we(en_we), .en_wdata(en_wdata), .en_mask(en_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 4'hF; o_ready = 1'b1; en_we = 1'b0; en_wdata = 4'h0;
    for (int i = 0; i < 4; i++) req_data[i*32 +: 32] = 32'h1000_0000 + i;
    step(); step();
    n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL reset_o_valid got %b exp 0", o_valid); end
    n_cmp++; if (o_data !== 32'h0) begin n_err++; $display("FAIL reset_o_data got %h exp 0", o_data); end
    n_cmp++; if (o_id !== 2'd0) begin n_err++; $display("FAIL reset_o_id got %0d exp 0", o_id); end
    n_cmp++; if (en_mask !== 4'hF) begin n_err++; $display("FAIL reset_en_mask got %b exp 1111", en_mask); end
    n_cmp++; if (req_ready !== 4'h0) begin n_err++; $display("FAIL reset_req_ready got %b exp 0000", req_ready); end
    @(negedge clk); rst_n = 1'b1; #1;
  endtask

  task automatic test_rotate();
    logic [3:0] exp_rdy;
    logic [1:0] exp_id;
    for (int c = 0; c < 5; c++) begin
      exp_rdy = 4'b0001 << (c % 4);
      n_cmp++; if (req_ready !== exp_rdy) begin n_err++; $display("FAIL rotate_grant c=%0d got %b exp %b", c, req_ready, exp_rdy); end
      if (c > 0) begin
        exp_id = 2'((c - 1) % 4);
        n_cmp++; if (o_valid !== 1'b1) begin n_err++; $display("FAIL rotate_o_valid c=%0d got %b exp 1", c, o_valid); end
        n_cmp++; if (o_id !== exp_id) begin n_err++; $display("FAIL rotate_o_id c=%0d got %0d exp %0d", c, o_id, exp_id); end
        n_cmp++; if (o_data !== 32'h1000_0000 + 32'(exp_id)) begin n_err++; $display("FAIL rotate_o_data c=%0d got %h exp %h", c, o_data, 32'h1000_0000 + 32'(exp_id)); end
      end
      step();
    end
    n_cmp++; if (o_id !== 2'd0 || o_valid !== 1'b1) begin n_err++; $display("FAIL rotate_last got id=%0d v=%b exp id=0 v=1", o_id, o_valid); end
  endtask

  task automatic test_backpressure();
    req_valid = 4'b0100; req_data[2*32 +: 32] = 32'hA5A5_A5A5; o_ready = 1'b1; #1;
    n_cmp++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL bp_accept2 got %b exp 0100", req_ready); end
    @(negedge clk); o_ready = 1'b0; req_valid = 4'hF; #1;
    for (int c = 0; c < 5; c++) begin
      n_cmp++;
      if (o_valid !== 1'b1 || o_data !== 32'hA5A5_A5A5 || o_id !== 2'd2 || req_ready !== 4'h0 || dut.ptr !== 2'd3) begin
        n_err++;
        $display("FAIL bp_hold c=%0d got v=%b d=%h id=%0d rdy=%b ptr=%0d exp v=1 d=a5a5a5a5 id=2 rdy=0000 ptr=3", c, o_valid, o_data, o_id, req_ready, dut.ptr);
      end
      step();
    end
    o_ready = 1'b1; #1;
    n_cmp++; if (req_ready !== 4'b1000) begin n_err++; $display("FAIL bp_release_grant got %b exp 1000", req_ready); end
    step();
    n_cmp++; if (o_id !== 2'd3 || o_data !== 32'h1000_0003) begin n_err++; $display("FAIL bp_next_out got id=%0d d=%h exp id=3 d=10000003", o_id, o_data); end
  endtask

  task automatic test_masking();
    logic [3:0] exp_seq [3] = '{4'b0100, 4'b0001, 4'b0100};
    en_we = 1'b1; en_wdata = 4'b0101; req_valid = 4'hF; o_ready = 1'b1; #1;
    n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL mask_write_cycle got %b exp 0001", req_ready); end
    @(negedge clk); en_we = 1'b0; #1;
    n_cmp++; if (en_mask !== 4'b0101) begin n_err++; $display("FAIL mask_value got %b exp 0101", en_mask); end
    for (int c = 0; c < 3; c++) begin
      n_cmp++; if (req_ready !== exp_seq[c]) begin n_err++; $display("FAIL mask_grant c=%0d got %b exp %b", c, req_ready, exp_seq[c]); end
      step();
    end
    n_cmp++; if (dut.ptr !== 2'd3) begin n_err++; $display("FAIL mask_ptr got %0d exp 3", dut.ptr); end
  endtask

  task automatic test_wrap_sparse();
    en_we = 1'b1; en_wdata = 4'hF; req_valid = 4'h0; o_ready = 1'b1;
    @(negedge clk); en_we = 1'b0; req_valid = 4'b0010; #1;
    n_cmp++; if (dut.ptr !== 2'd3 || o_valid !== 1'b0) begin n_err++; $display("FAIL wrap_idle got ptr=%0d v=%b exp ptr=3 v=0", dut.ptr, o_valid); end
    n_cmp++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL wrap_grant1 got %b exp 0010", req_ready); end
    @(negedge clk); req_valid = 4'b1000; #1;
    n_cmp++; if (dut.ptr !== 2'd2 || o_id !== 2'd1) begin n_err++; $display("FAIL wrap_ptr2 got ptr=%0d id=%0d exp ptr=2 id=1", dut.ptr, o_id); end
    n_cmp++; if (req_ready !== 4'b1000) begin n_err++; $display("FAIL wrap_grant3 got %b exp 1000", req_ready); end
    step();
    n_cmp++; if (dut.ptr !== 2'd0 || o_id !== 2'd3) begin n_err++; $display("FAIL wrap_ptr0 got ptr=%0d id=%0d exp ptr=0 id=3", dut.ptr, o_id); end
  endtask

  task automatic test_drain_empty_mask();
    req_valid = 4'b0010; req_data[1*32 +: 32] = 32'h1111_1111; o_ready = 1'b1; #1;
    n_cmp++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL drain_load got %b exp 0010", req_ready); end
    @(negedge clk); req_valid = 4'h0; o_ready = 1'b0; en_we = 1'b1; en_wdata = 4'h0;
    @(negedge clk); en_we = 1'b0; req_valid = 4'hF; #1;
    n_cmp++;
    if (o_valid !== 1'b1 || o_id !== 2'd1 || o_data !== 32'h1111_1111 || en_mask !== 4'h0 || req_ready !== 4'h0) begin
      n_err++;
      $display("FAIL drain_hold got v=%b id=%0d d=%h mask=%b rdy=%b exp v=1 id=1 d=11111111 mask=0000 rdy=0000", o_valid, o_id, o_data, en_mask, req_ready);
    end
    o_ready = 1'b1; #1;
    n_cmp++; if (req_ready !== 4'h0) begin n_err++; $display("FAIL drain_no_grant got %b exp 0000", req_ready); end
    step();
    n_cmp++; if (o_valid !== 1'b0 || req_ready !== 4'h0) begin n_err++; $display("FAIL drain_empty got v=%b rdy=%b exp v=0 rdy=0000", o_valid, req_ready); end
  endtask

  task automatic test_reset_mid_transfer();
    en_we = 1'b1; en_wdata = 4'b0111; req_valid = 4'h0;
    @(negedge clk); en_we = 1'b0; req_valid = 4'b0100; o_ready = 1'b1; #1;
    n_cmp++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL rmid_accept got %b exp 0100", req_ready); end
    @(negedge clk); o_ready = 1'b0; req_valid = 4'hF; #1;
    n_cmp++; if (o_valid !== 1'b1 || dut.ptr !== 2'd3 || en_mask !== 4'b0111) begin n_err++; $display("FAIL rmid_pre got v=%b ptr=%0d mask=%b exp v=1 ptr=3 mask=0111", o_valid, dut.ptr, en_mask); end
    #1 rst_n = 1'b0; #1;
    n_cmp++;
    if (o_valid !== 1'b0 || en_mask !== 4'hF || dut.ptr !== 2'd0 || req_ready !== 4'h0) begin
      n_err++;
      $display("FAIL rmid_async got v=%b mask=%b ptr=%0d rdy=%b exp v=0 mask=1111 ptr=0 rdy=0000", o_valid, en_mask, dut.ptr, req_ready);
    end
    @(negedge clk); rst_n = 1'b1; req_valid = 4'b1010; o_ready = 1'b1; #1;
    n_cmp++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL rmid_first_grant got %b exp 0010", req_ready); end
    step();
    n_cmp++; if (o_valid !== 1'b1 || o_id !== 2'd1) begin n_err++; $display("FAIL rmid_first_out got v=%b id=%0d exp v=1 id=1", o_valid, o_id); end
  endtask

  initial begin
    req_data = '0;
    test_reset();
    test_rotate();
    test_backpressure();
    test_masking();
    test_wrap_sparse();
    test_drain_empty_mask();
    test_reset_mid_transfer();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sirv_gnrl_rr_arb.md
Name: sirv_gnrl_rr_arb

Overview:
- N-way round-robin arbiter with a registered output stage; shares one downstream valid/ready channel among N requesters.
- Per-requester enable mask register resets to all-ones, so every requester is eligible out of reset. Software or a scheduler disables requesters by writing the mask.
- Sits in front of shared resources such as a writeback port or a memory request queue. Thread-select logic uses it to pick one active thread per cycle.

Parameters:
- N, 4, number of requesters; legal range 2..16.
- DW, 32, payload width per requester.
- IW, 2, id width; must equal clog2(N).

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low.
- req_valid  input  N  per-requester request valid.
- req_data  input  N*DW  payloads; requester i occupies bits [i*DW +: DW].
- req_ready  output  N  per-requester accept; at most one bit high per cycle.
- o_valid  output  1  output entry valid (registered).
- o_data  output  DW  output payload (registered).
- o_id  output  IW  index of the requester whose payload is in o_data (registered).
- o_ready  input  1  downstream accept.
- en_we  input  1  enable-mask write strobe.
- en_wdata  input  N  new enable mask.
- en_mask  output  N  current enable mask (registered).

Behaviour:
- Reset values: o_valid=0, o_data=0, o_id=0, en_mask=all ones, priority pointer ptr=0. req_ready is combinational and is 0 during reset.
- eligible = req_valid & en_mask. All arbitration uses the mask value held at the start of the cycle.
- Winner: the first eligible index, searching ptr, ptr+1, ..., N-1, 0, ..., ptr-1 (wrap mod N).
- Output stage can load (load_ok) when o_valid==0 or o_ready==1.
- Accept: when load_ok and eligible != 0, set req_ready[winner]=1; all other req_ready bits are 0.
- On the next edge after an accept: o_valid<=1, o_data<=req_data[winner], o_id<=winner, ptr<=(winner+1) mod N.
- When o_valid && o_ready and there is no accept: o_valid<=0 on the next edge. o_data and o_id hold their values.
- Latency: 1 cycle from accept to o_valid. Throughput: 1 transfer per cycle while o_ready is held high.
- Backpressure: while o_valid && !o_ready, o_data and o_id must hold stable, all req_ready bits are 0, and ptr holds.
- ptr only changes on an accept. Idle cycles do not rotate priority.
- Requester contract: it holds req_valid and req_data until it sees req_ready. The arbiter does not check this.
- en_we: en_mask<=en_wdata on the next edge. The new mask first affects arbitration in the cycle after the write.
- An entry already in the output stage is always delivered, even if its requester is masked off afterwards.
- en_wdata=0: no further accepts. o_valid drains normally.
- Single eligible requester: it wins every load_ok cycle regardless of ptr.
- Winner N-1: ptr wraps to 0.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous). Any in-flight output entry is dropped.
- Behaviour of req_valid bits for requesters that are masked off: they are ignored.

Test Plan:
- Reset check: N=4, all req_valid=1, o_ready=1 -> en_mask=4'b1111. Grants rotate 0,1,2,3,0 on consecutive cycles. o_id follows one cycle later, o_valid stays high continuously.
- Backpressure: accept requester 2 with data 0xA5A5A5A5, then o_ready=0 for 5 cycles -> o_data=0xA5A5A5A5 and o_id=2 stable, req_ready=0, ptr stays 3. o_ready=1 -> next grant goes to requester 3 if it is valid.
- Masking: write en_wdata=4'b0101 with all req_valid=1 -> from the second cycle after the write, grants alternate 0,2,0,2. Requesters 1 and 3 never see req_ready.
- Wrap and sparse requests: ptr=3, only req_valid[1]=1 -> requester 1 is granted and ptr becomes 2. Then only req_valid[3]=1 -> requester 3 is granted and ptr wraps to 0.
- Drain with empty mask: o_valid=1 holding an entry from requester 1, write en_wdata=0 -> the held entry is delivered on o_ready. o_valid then goes low and no req_ready is asserted.
- Reset mid-transfer: o_valid=1, o_ready=0, assert rst_n=0 asynchronously between edges -> o_valid=0 immediately, en_mask=4'b1111, ptr=0. After release, the first grant goes to the lowest eligible index.
